recv_m_1ofn: RTL and testbench
==============================

Name: recv_m_1ofn

Overview:
- Receive-side adapter from a delay-insensitive e1ofN channel (M digits, each a one-hot group of N rails, plus an enable/acknowledge) to a synchronous valid/ready interface.
- Used in front of every clocked RTL body that consumes an asynchronous channel; for example, a 9-bit flit channel is M=9, N=2.
- Holds exactly one token. It decodes the one-hot digits to binary, and back-pressure is applied by withholding the enable.

Parameters:
- M, 9, number of 1-of-N digits in the codeword.
- N, 2, rails per digit; N must be at least 2.
- SYNC_STAGES, 2, flip-flop stages per rail in the synchronizer; must be at least 2.
- Derived, not overridable: B = max(1, clog2(N)) bits per digit, and W = M*B data width.

Ports:
- CLK, input, 1, single clock.
- _RESET, input, 1, asynchronous active-low reset.
- in_rails, input, M*N, channel rails. Digit d, rail r is at index d*N+r. These rails are asynchronous to CLK.
- in_en, output, 1, enable to the sender. 1 means ready for a new codeword; 0 acknowledges the current one.
- rtl_data, output, W, decoded token. Digit d occupies bits [d*B +: B].
- rtl_valid, output, 1, a token is held in rtl_data.
- rtl_ready, input, 1, the consumer accepts the token on a cycle where rtl_valid and rtl_ready are both 1.

Behaviour:
- Reset (asynchronous, while _RESET=0):
  - in_en=1, rtl_valid=0, rtl_data=0.
  - All synchronizer flops are cleared; the FSM is in IDLE.
- Synchronizer: each rail passes through SYNC_STAGES flops. All completion and neutral detection uses only the synchronized copy.
- Completion:
  - A digit is complete when exactly one of its rails is 1.
  - The codeword is complete when all M digits are complete.
  - A digit with more than one rail high is never complete; the block keeps waiting and does not flag an error.
  - Neutral means every synchronized rail is 0.
- Decode: the index of the high rail in digit d becomes the B-bit value of that digit. Example, N=2: rail1 high gives bit 1; rail0 high gives bit 0.
- FSM states: IDLE, FULL, DRAIN.
- IDLE: in_en=1, rtl_valid=0.
  - On an edge where the codeword is complete: latch the decoded data, set rtl_valid=1 and in_en=0 on that same edge, and go to FULL.
- FULL: in_en=0, rtl_valid=1, rtl_data held stable.
  - Consumer handshake and neutral in the same cycle: rtl_valid=0, in_en=1, go to IDLE.
  - Handshake without neutral: rtl_valid=0, go to DRAIN.
  - Neutral without handshake: stay in FULL with in_en held at 0. This is the back-pressure path.
- DRAIN: in_en=0, rtl_valid=0.
  - When neutral: in_en=1, go to IDLE.
- in_en and rtl_valid are driven directly from flops; no combinational path from the inputs reaches any output.
- Latency: with rails stable before edge 0 and SYNC_STAGES=2, rtl_valid and rtl_data appear and in_en falls at edge 2.
- A new codeword is never accepted before neutral has been seen and the previous token has been consumed.
- rtl_data keeps its last value after consumption; it is only reloaded on the next capture.
- Reset asserted mid-transfer forces the reset values immediately. Any token in flight is discarded.

Decomposition:
- Shared package e1ofn_pkg:
  - a clog2-based digit-width function;
  - the FSM state enum {IDLE, FULL, DRAIN};
  - the rail-index convention as a function, idx(d, r) = d*N + r.
- The companion send-side adapter, send_m_1ofn, uses the same package.
- One sub-module: rail_sync, a SYNC_STAGES-deep, width-parameterised synchronizer with asynchronous active-low clear.

Test Plan:
- Reset, then release _RESET → in_en=1, rtl_valid=0, rtl_data=0. Drive the M=9, N=2 codeword for 0x1A5 → at edge 2, rtl_data=0x1A5, rtl_valid=1, in_en=0.
- After that capture, hold rtl_ready=0 and drive neutral for 10 cycles → rtl_valid stays 1 and in_en stays 0. Assert rtl_ready for one cycle → rtl_valid=0 and in_en=1 on the next edge.
- Capture, consume immediately with rtl_ready=1, and keep the rails non-neutral for 5 cycles → rtl_valid=0 and in_en stays 0. Drive neutral → in_en=1 after the synchronizer delay.
- Drive only 8 of 9 digits, or digit 3 with both rails high, for 20 cycles → no capture; in_en stays 1.
- With M=2, N=4, drive rail2 on digit 0 and rail3 on digit 1 → rtl_data=4'b1110.
- Assert _RESET while in FULL → rtl_valid=0 and in_en=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/recv_m_1ofn_pkg.sv
// Shared definitions for the e1ofN channel adapters (recv_m_1ofn, send_m_1ofn).
//   digit_bits(n) : binary width of one 1-of-n digit, never less than 1
//   state_e       : adapter FSM states
//   idx(d, r, n)  : flat rail index of digit d, rail r in an n-rail code
package e1ofn_pkg;

   function automatic int digit_bits(input int n);
      int b;
      b = $clog2(n);
      return (b < 1) ? 1 : b;
   endfunction

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FULL  = 2'd1,
      DRAIN = 2'd2
   } state_e;

   function automatic int idx(input int d, input int r, input int n);
      return d * n + r;
   endfunction

endpackage

// File: rtl/recv_m_1ofn_if.sv
// Channel bundle between an e1ofN sender, the receive adapter and its
// synchronous consumer.
//   in_rails  : M*N delay-insensitive rails, digit d rail r at d*N+r
//   in_en     : enable back to the sender (1 = send, 0 = acknowledge)
//   rtl_data  : decoded token, digit d at [d*B +: B]
//   rtl_valid : token held
//   rtl_ready : consumer accepts when valid and ready are both 1
// slave  : the receive adapter side
// master : the environment (sender + consumer) side
interface recv_m_1ofn_if
   import e1ofn_pkg::*;
#(
   parameter int M = 9,
   parameter int N = 2
);
   localparam int B = digit_bits(N);
   localparam int W = M * B;

   logic [M*N-1:0] in_rails;
   logic           in_en;
   logic [W-1:0]   rtl_data;
   logic           rtl_valid;
   logic           rtl_ready;

   modport slave (
      input  in_rails,
      input  rtl_ready,
      output in_en,
      output rtl_data,
      output rtl_valid
   );

   modport master (
      output in_rails,
      output rtl_ready,
      input  in_en,
      input  rtl_data,
      input  rtl_valid
   );
endinterface

// File: rtl/recv_m_1ofn_rail_sync.sv
// Multi-stage flop synchronizer, one independent chain per bit.
//   clk_i   : destination clock
//   rst_n_i : asynchronous active-low clear of every stage
//   d_i     : asynchronous inputs
//   q_o     : synchronized outputs, STAGES cycles behind d_i
module rail_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [STAGES-1:0][WIDTH-1:0] stage_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stage_q <= '0;
      end else begin
         stage_q <= {stage_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = stage_q[STAGES-1];
endmodule

// File: rtl/recv_m_1ofn.sv
// Receive adapter: e1ofN channel (M digits of N rails + enable) to a
// one-token synchronous valid/ready stream.
//   CLK    : clock
//   _RESET : asynchronous active-low reset
//   bus    : channel bundle (slave side), see recv_m_1ofn_if
//
// state | meaning
// IDLE  | enable high, waiting for a complete codeword
// FULL  | token held, enable low, waiting for the consumer
// DRAIN | token consumed, enable low, waiting for the rails to go neutral
module recv_m_1ofn
   import e1ofn_pkg::*;
#(
   parameter int M           = 9,
   parameter int N           = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic          CLK,
   input  logic          _RESET,
   recv_m_1ofn_if.slave  bus
);
   localparam int B = digit_bits(N);
   localparam int W = M * B;

   logic [M*N-1:0] rails_s;
   logic [W-1:0]   dec_data;
   logic           complete;
   logic           neutral;
   logic           handshake;

   state_e         state_q, state_d;
   logic           en_q, en_d;
   logic           valid_q, valid_d;
   logic [W-1:0]   data_q, data_d;

   rail_sync #(
      .WIDTH  (M*N),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i   (CLK),
      .rst_n_i (_RESET),
      .d_i     (bus.in_rails),
      .q_o     (rails_s)
   );

   // A digit counts as complete only when exactly one rail is high, so a
   // glitching multi-rail digit simply holds off capture.
   always_comb begin
      logic [N-1:0] digit;
      logic [B-1:0] val;
      complete = 1'b1;
      dec_data = '0;
      for (int d = 0; d < M; d++) begin
         digit = rails_s[idx(d, 0, N) +: N];
         if (digit == '0 || (digit & (digit - N'(1))) != '0) begin
            complete = 1'b0;
         end
         val = '0;
         for (int r = 0; r < N; r++) begin
            if (digit[r]) begin
               val = val | B'(r);
            end
         end
         dec_data[d*B +: B] = val;
      end
   end

   assign neutral   = (rails_s == '0);
   assign handshake = valid_q & bus.rtl_ready;

   always_ff @(posedge CLK or negedge _RESET) begin
      if (!_RESET) begin
         state_q <= IDLE;
         en_q    <= 1'b1;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      en_d    = en_q;
      valid_d = valid_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: begin
            en_d    = 1'b1;
            valid_d = 1'b0;
            if (complete) begin
               data_d  = dec_data;
               valid_d = 1'b1;
               en_d    = 1'b0;
               state_d = FULL;
            end
         end
         FULL: begin
            // Neutral alone does not reopen the enable: that would let a
            // second codeword in before the held token is consumed.
            en_d    = 1'b0;
            valid_d = 1'b1;
            if (handshake) begin
               valid_d = 1'b0;
               if (neutral) begin
                  en_d    = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            en_d    = 1'b0;
            valid_d = 1'b0;
            if (neutral) begin
               en_d    = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            en_d    = 1'b1;
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign bus.in_en     = en_q;
   assign bus.rtl_valid = valid_q;
   assign bus.rtl_data  = data_q;
endmodule

// File: tb/tb_recv_m_1ofn.sv
// Bench for recv_m_1ofn: directed checks on M=9/N=2 and M=2/N=4 instances,
// then a randomized sender/consumer run scored against an encoded-value queue.
module tb_recv_m_1ofn;
   import e1ofn_pkg::*;

   logic CLK = 1'b0;
   logic rst_n;
   always #5 CLK = ~CLK;

   recv_m_1ofn_if #(.M(9), .N(2)) b9();
   recv_m_1ofn_if #(.M(2), .N(4)) b4();

   recv_m_1ofn #(.M(9), .N(2), .SYNC_STAGES(2)) dut9 (
      .CLK    (CLK),
      ._RESET (rst_n),
      .bus    (b9.slave)
   );

   recv_m_1ofn #(.M(2), .N(4), .SYNC_STAGES(2)) dut4 (
      .CLK    (CLK),
      ._RESET (rst_n),
      .bus    (b4.slave)
   );

   int checks = 0;
   int errors = 0;
   int popped = 0;
   logic [8:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference encoder: bit d of the value selects rail 0 or rail 1 of digit d.
   function automatic logic [17:0] enc9(input logic [8:0] v);
      logic [17:0] r;
      r = '0;
      for (int d = 0; d < 9; d++) r[d*2 + (v[d] ? 1 : 0)] = 1'b1;
      return r;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_en(input logic v, input string name);
      int n;
      n = 0;
      while (b9.in_en !== v && n < 300) begin
         tick();
         n++;
      end
      chk(name, 64'(b9.in_en), 64'(v));
   endtask

   // Monitor: pops the scoreboard on every accepted token and checks that a
   // held token does not change while waiting for the consumer.
   logic       prev_hold = 1'b0;
   logic [8:0] prev_data = '0;
   always @(negedge CLK) begin
      if (!rst_n) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold && b9.rtl_valid) chk("data_stable", 64'(b9.rtl_data), 64'(prev_data));
         if (b9.rtl_valid && b9.rtl_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL token_unexpected: got 0x%0h expected none", b9.rtl_data);
            end else begin
               chk("token_data", 64'(b9.rtl_data), 64'(exp_q.pop_front()));
            end
            popped++;
            prev_hold = 1'b0;
         end else begin
            prev_hold = b9.rtl_valid;
            prev_data = b9.rtl_data;
         end
      end
   end

   initial begin
      logic [8:0] v;
      int bad;
      int base;

      b9.in_rails  = '0;
      b9.rtl_ready = 1'b0;
      b4.in_rails  = '0;
      b4.rtl_ready = 1'b0;
      rst_n        = 1'b0;
      #12;
      chk("rst_en", 64'(b9.in_en), 64'(1));
      chk("rst_valid", 64'(b9.rtl_valid), 64'(0));
      chk("rst_data", 64'(b9.rtl_data), 64'(0));
      chk("rst_en_m2n4", 64'(b4.in_en), 64'(1));
      tick();
      rst_n = 1'b1;
      tick();

      // Latency: rails stable before edge 0, token visible at edge 2.
      b9.in_rails = enc9(9'h1A5);
      exp_q.push_back(9'h1A5);
      tick();
      chk("lat_edge0_valid", 64'(b9.rtl_valid), 64'(0));
      tick();
      chk("lat_edge1_valid", 64'(b9.rtl_valid), 64'(0));
      chk("lat_edge1_en", 64'(b9.in_en), 64'(1));
      tick();
      chk("lat_edge2_valid", 64'(b9.rtl_valid), 64'(1));
      chk("lat_edge2_data", 64'(b9.rtl_data), 64'(9'h1A5));
      chk("lat_edge2_en", 64'(b9.in_en), 64'(0));

      // Back-pressure: neutral without consumption keeps the enable low.
      b9.in_rails = '0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (b9.rtl_valid !== 1'b1 || b9.in_en !== 1'b0) bad++;
      end
      chk("backpressure_hold", 64'(bad), 64'(0));
      b9.rtl_ready = 1'b1;
      tick();
      b9.rtl_ready = 1'b0;
      chk("consume_valid", 64'(b9.rtl_valid), 64'(0));
      chk("consume_en", 64'(b9.in_en), 64'(1));

      // Consume immediately while rails stay non-neutral: drain path.
      v = 9'h0C3;
      b9.in_rails  = enc9(v);
      b9.rtl_ready = 1'b1;
      exp_q.push_back(v);
      tick();
      tick();
      tick();
      chk("drain_capture", 64'(b9.rtl_valid), 64'(1));
      tick();
      chk("drain_valid", 64'(b9.rtl_valid), 64'(0));
      chk("drain_data_kept", 64'(b9.rtl_data), 64'(v));
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (b9.in_en !== 1'b0 || b9.rtl_valid !== 1'b0) bad++;
      end
      chk("drain_en_low", 64'(bad), 64'(0));
      b9.in_rails = '0;
      tick();
      tick();
      chk("drain_sync_en_low", 64'(b9.in_en), 64'(0));
      tick();
      chk("drain_neutral_en", 64'(b9.in_en), 64'(1));
      b9.rtl_ready = 1'b0;

      // Incomplete codewords: missing digit 8, then digit 3 with both rails.
      b9.in_rails = enc9(9'h0AB) & ~(18'h3 << 16);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (b9.in_en !== 1'b1 || b9.rtl_valid !== 1'b0) bad++;
      end
      chk("partial_no_capture", 64'(bad), 64'(0));
      b9.in_rails = '0;
      repeat (3) tick();
      b9.in_rails = enc9(9'h155) | (18'h3 << 6);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (b9.in_en !== 1'b1 || b9.rtl_valid !== 1'b0) bad++;
      end
      chk("dual_rail_no_capture", 64'(bad), 64'(0));
      b9.in_rails = '0;
      repeat (3) tick();

      // M=2, N=4: rail 2 of digit 0 and rail 3 of digit 1.
      b4.in_rails = 8'((1 << 2) | (1 << (4 + 3)));
      repeat (3) tick();
      chk("m2n4_valid", 64'(b4.rtl_valid), 64'(1));
      chk("m2n4_data", 64'(b4.rtl_data), 64'(4'b1110));

      // Reset in FULL takes effect without a clock edge; token is dropped.
      b9.in_rails = enc9(9'h0F3);
      repeat (3) tick();
      chk("pre_reset_full", 64'(b9.rtl_valid), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 64'(b9.rtl_valid), 64'(0));
      chk("async_rst_en", 64'(b9.in_en), 64'(1));
      chk("async_rst_data", 64'(b9.rtl_data), 64'(0));
      chk("async_rst_valid_m2n4", 64'(b4.rtl_valid), 64'(0));
      b9.in_rails = '0;
      b4.in_rails = '0;
      #20;
      tick();
      rst_n = 1'b1;
      tick();

      // Randomized traffic against the scoreboard.
      base = popped;
      fork
         begin
            logic [8:0] rv;
            for (int t = 0; t < 40; t++) begin
               wait_en(1'b1, "rnd_en_high");
               repeat ($urandom_range(0, 3)) tick();
               rv = 9'($urandom);
               b9.in_rails = enc9(rv);
               exp_q.push_back(rv);
               wait_en(1'b0, "rnd_en_low");
               repeat ($urandom_range(0, 4)) tick();
               b9.in_rails = '0;
            end
         end
         begin
            int guard;
            guard = 0;
            while (popped < base + 40 && guard < 20000) begin
               b9.rtl_ready = 1'($urandom_range(0, 1));
               tick();
               guard++;
            end
            b9.rtl_ready = 1'b0;
         end
      join
      chk("rnd_all_consumed", 64'(popped), 64'(base + 40));
      chk("rnd_queue_empty", 64'(exp_q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
